spi_master_txn_arbiter: RTL and testbench

Shares one spi_master_controller between N_REQ requesters, for example a core and a DMA channel. Each requester submits a transaction descriptor: chip select, direction, command, command length and data length. The block arbitrates round-robin, programs the controller's command/length/CS/rd/wr inputs, and steers the 32-bit TX/RX streams to and from the granted requester until the controller signals eot. It sits between the requesters and the controller's spi_cmd/spi_rd/spi_wr/spi_ctrl_data_* interface.

---
 rtl/spi_master_txn_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_spi_master_txn_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_txn_arbiter.sv
// spi_master_txn_arbiter
//
// Shares one SPI master controller between N_REQ requesters. Each requester
// offers a transaction descriptor (chip select, direction, command, command
// length, data length). A round-robin arbiter picks one. The block then
// programs the controller and steers the 32-bit TX/RX streams to and from the
// granted requester until the controller raises eot.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   When defined, a 16-bit BUSY watchdog aborts a transaction after
//   TIMEOUT_CYCLES cycles without eot. The abort pulses spi_swrst and
//   req_err_o[grant]. When undefined, spi_swrst and req_err_o stay 0.
//
// Ports:
//   HCLK, HRESETn                      clock, asynchronous active-low reset
//   req_valid_i / req_ready_o          descriptor handshake (ready = accept pulse)
//   req_cs_i, req_wr_i, req_cmd_i,
//   req_cmd_len_i, req_data_len_i      packed per-requester descriptors
//   req_tx_data_i/_valid_i/_ready_o    per-requester TX stream
//   req_rx_data_o/_valid_o/_ready_i    shared RX data, per-requester valid/ready
//   req_done_o, req_err_o              completion / timeout pulses
//   spi_cmd, spi_cmd_len, spi_data_len,
//   spi_csreg, spi_rd, spi_wr,
//   spi_swrst                          controller programming outputs
//   spi_ctrl_data_tx*/rx*              controller stream interface
//   eot                                controller end of transaction

module spi_master_txn_arbiter #(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [2*N_REQ-1:0]    req_cs_i,
    input  logic [N_REQ-1:0]      req_wr_i,
    input  logic [32*N_REQ-1:0]   req_cmd_i,
    input  logic [6*N_REQ-1:0]    req_cmd_len_i,
    input  logic [16*N_REQ-1:0]   req_data_len_i,
    input  logic [32*N_REQ-1:0]   req_tx_data_i,
    input  logic [N_REQ-1:0]      req_tx_valid_i,
    output logic [N_REQ-1:0]      req_tx_ready_o,
    output logic [31:0]           req_rx_data_o,
    output logic [N_REQ-1:0]      req_rx_valid_o,
    input  logic [N_REQ-1:0]      req_rx_ready_i,
    output logic [N_REQ-1:0]      req_done_o,
    output logic [N_REQ-1:0]      req_err_o,
    output logic [31:0]           spi_cmd,
    output logic [5:0]            spi_cmd_len,
    output logic [15:0]           spi_data_len,
    output logic [3:0]            spi_csreg,
    output logic                  spi_rd,
    output logic                  spi_wr,
    output logic                  spi_swrst,
    output logic [31:0]           spi_ctrl_data_tx,
    output logic                  spi_ctrl_data_tx_valid,
    input  logic                  spi_ctrl_data_tx_ready,
    input  logic [31:0]           spi_ctrl_data_rx,
    input  logic                  spi_ctrl_data_rx_valid,
    output logic                  spi_ctrl_data_rx_ready,
    input  logic                  eot
);

    localparam int unsigned PtrW = $clog2(N_REQ);

    // Elaboration-time parameter range checks.
    if (N_REQ < 2 || N_REQ > 8) begin : gen_bad_n_req
        $error("N_REQ must be in the range 2..8");
    end
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must be in the range 1..65535");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0] grant_q, grant_d;
    logic [1:0]      cs_q, cs_d;
    logic            wr_q, wr_d;
    logic [31:0]     cmd_q, cmd_d;
    logic [5:0]      cmd_len_q, cmd_len_d;
    logic [15:0]     data_len_q, data_len_d;

    logic            any_valid;
    logic [PtrW-1:0] winner;
    logic [PtrW:0]   arb_sum;
    logic            accept;
    logic            timeout_hit;
    logic [PtrW-1:0] grant_inc;

    logic [1:0]      sel_cs;
    logic            sel_wr;
    logic [31:0]     sel_cmd;
    logic [5:0]      sel_cmd_len;
    logic [15:0]     sel_data_len;

    logic [31:0]     g_tx_data;
    logic            g_tx_valid;
    logic            g_rx_ready;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        any_valid = 1'b0;
        winner    = rr_ptr_q;
        arb_sum   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            arb_sum = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
            if (arb_sum >= (PtrW+1)'(N_REQ)) begin
                arb_sum = arb_sum - (PtrW+1)'(N_REQ);
            end
            if (!any_valid && req_valid_i[arb_sum[PtrW-1:0]]) begin
                any_valid = 1'b1;
                winner    = arb_sum[PtrW-1:0];
            end
        end
    end

    // Descriptor of the arbitration winner.
    always_comb begin
        sel_cs       = '0;
        sel_wr       = 1'b0;
        sel_cmd      = '0;
        sel_cmd_len  = '0;
        sel_data_len = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner == PtrW'(i)) begin
                sel_cs       = req_cs_i[2*i +: 2];
                sel_wr       = req_wr_i[i];
                sel_cmd      = req_cmd_i[32*i +: 32];
                sel_cmd_len  = req_cmd_len_i[6*i +: 6];
                sel_data_len = req_data_len_i[16*i +: 16];
            end
        end
    end

    // Stream signals of the current grant holder.
    always_comb begin
        g_tx_data  = '0;
        g_tx_valid = 1'b0;
        g_rx_ready = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q == PtrW'(i)) begin
                g_tx_data  = req_tx_data_i[32*i +: 32];
                g_tx_valid = req_tx_valid_i[i];
                g_rx_ready = req_rx_ready_i[i];
            end
        end
    end

    assign accept    = (state_q == StIdle) && any_valid;
    assign grant_inc = (grant_q == PtrW'(N_REQ - 1)) ? '0 : grant_q + PtrW'(1);

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Cleared while entering BUSY, counts every BUSY cycle.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == StIssue) begin
            tmo_cnt_d = '0;
        end else if (state_q == StBusy) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // eot in the expiry cycle takes the normal completion path.
    assign timeout_hit = (state_q == StBusy) && !eot && (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_valid) state_d = StIssue;
            StIssue: state_d = StBusy;
            StBusy: begin
                if (eot) begin
                    state_d = StDone;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Descriptor latch, grant and round-robin pointer.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cs_d       = cs_q;
        wr_d       = wr_q;
        cmd_d      = cmd_q;
        cmd_len_d  = cmd_len_q;
        data_len_d = data_len_q;
        if (accept) begin
            grant_d    = winner;
            cs_d       = sel_cs;
            wr_d       = sel_wr;
            cmd_d      = sel_cmd;
            cmd_len_d  = sel_cmd_len;
            data_len_d = sel_data_len;
        end
        if (state_q == StDone || timeout_hit) begin
            rr_ptr_d = grant_inc;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cs_q       <= '0;
            wr_q       <= 1'b0;
            cmd_q      <= '0;
            cmd_len_q  <= '0;
            data_len_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            cmd_q      <= cmd_d;
            cmd_len_q  <= cmd_len_d;
            data_len_q <= data_len_d;
        end
    end

    // FSM outputs.
    always_comb begin
        req_ready_o            = '0;
        req_tx_ready_o         = '0;
        req_rx_data_o          = '0;
        req_rx_valid_o         = '0;
        req_done_o             = '0;
        req_err_o              = '0;
        spi_cmd                = '0;
        spi_cmd_len            = '0;
        spi_data_len           = '0;
        spi_csreg              = '0;
        spi_rd                 = 1'b0;
        spi_wr                 = 1'b0;
        spi_swrst              = 1'b0;
        spi_ctrl_data_tx       = '0;
        spi_ctrl_data_tx_valid = 1'b0;
        spi_ctrl_data_rx_ready = 1'b0;

        // Controller programming is held from ISSUE through DONE.
        if (state_q != StIdle) begin
            spi_cmd      = cmd_q;
            spi_cmd_len  = cmd_len_q;
            spi_data_len = data_len_q;
            spi_csreg    = 4'b0001 << cs_q;
        end

        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    req_ready_o[winner] = 1'b1;
                end
            end
            StIssue: begin
                spi_wr = wr_q;
                spi_rd = !wr_q;
            end
            StBusy: begin
                spi_ctrl_data_tx        = g_tx_data;
                spi_ctrl_data_tx_valid  = g_tx_valid;
                req_tx_ready_o[grant_q] = spi_ctrl_data_tx_ready;
                req_rx_data_o           = spi_ctrl_data_rx;
                req_rx_valid_o[grant_q] = spi_ctrl_data_rx_valid;
                spi_ctrl_data_rx_ready  = g_rx_ready;
                if (timeout_hit) begin
                    spi_swrst          = 1'b1;
                    req_err_o[grant_q] = 1'b1;
                end
            end
            StDone: begin
                req_done_o[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_master_txn_arbiter.sv
// Self-checking bench for spi_master_txn_arbiter (N_REQ=2, TIMEOUT_CYCLES=20).
// Stimulus pushes expected events into a queue; a monitor on the falling edge
// pops and compares whenever the DUT presents an accept, start, stream
// handshake, done or error.

module tb_spi_master_txn_arbiter;

    localparam int N = 2;

    localparam logic [3:0] KReady = 4'd1;
    localparam logic [3:0] KStart = 4'd2;
    localparam logic [3:0] KTx    = 4'd3;
    localparam logic [3:0] KRx    = 4'd4;
    localparam logic [3:0] KDone  = 4'd5;
    localparam logic [3:0] KErr   = 4'd6;

    logic            HCLK = 1'b0;
    logic            HRESETn = 1'b0;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [2*N-1:0]  req_cs_i;
    logic [N-1:0]    req_wr_i;
    logic [32*N-1:0] req_cmd_i;
    logic [6*N-1:0]  req_cmd_len_i;
    logic [16*N-1:0] req_data_len_i;
    logic [32*N-1:0] req_tx_data_i;
    logic [N-1:0]    req_tx_valid_i;
    logic [N-1:0]    req_tx_ready_o;
    logic [31:0]     req_rx_data_o;
    logic [N-1:0]    req_rx_valid_o;
    logic [N-1:0]    req_rx_ready_i;
    logic [N-1:0]    req_done_o;
    logic [N-1:0]    req_err_o;
    logic [31:0]     spi_cmd;
    logic [5:0]      spi_cmd_len;
    logic [15:0]     spi_data_len;
    logic [3:0]      spi_csreg;
    logic            spi_rd, spi_wr, spi_swrst;
    logic [31:0]     spi_ctrl_data_tx;
    logic            spi_ctrl_data_tx_valid, spi_ctrl_data_tx_ready;
    logic [31:0]     spi_ctrl_data_rx;
    logic            spi_ctrl_data_rx_valid, spi_ctrl_data_rx_ready;
    logic            eot;

    spi_master_txn_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .HCLK                   (HCLK),
        .HRESETn                (HRESETn),
        .req_valid_i            (req_valid_i),
        .req_ready_o            (req_ready_o),
        .req_cs_i               (req_cs_i),
        .req_wr_i               (req_wr_i),
        .req_cmd_i              (req_cmd_i),
        .req_cmd_len_i          (req_cmd_len_i),
        .req_data_len_i         (req_data_len_i),
        .req_tx_data_i          (req_tx_data_i),
        .req_tx_valid_i         (req_tx_valid_i),
        .req_tx_ready_o         (req_tx_ready_o),
        .req_rx_data_o          (req_rx_data_o),
        .req_rx_valid_o         (req_rx_valid_o),
        .req_rx_ready_i         (req_rx_ready_i),
        .req_done_o             (req_done_o),
        .req_err_o              (req_err_o),
        .spi_cmd                (spi_cmd),
        .spi_cmd_len            (spi_cmd_len),
        .spi_data_len           (spi_data_len),
        .spi_csreg              (spi_csreg),
        .spi_rd                 (spi_rd),
        .spi_wr                 (spi_wr),
        .spi_swrst              (spi_swrst),
        .spi_ctrl_data_tx       (spi_ctrl_data_tx),
        .spi_ctrl_data_tx_valid (spi_ctrl_data_tx_valid),
        .spi_ctrl_data_tx_ready (spi_ctrl_data_tx_ready),
        .spi_ctrl_data_rx       (spi_ctrl_data_rx),
        .spi_ctrl_data_rx_valid (spi_ctrl_data_rx_valid),
        .spi_ctrl_data_rx_ready (spi_ctrl_data_rx_ready),
        .eot                    (eot)
    );

    always #5 HCLK = ~HCLK;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [67:0] exp_q[$];
    logic [31:0] rxw[3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic expect_ev(input logic [3:0] k, input logic [63:0] d);
        exp_q.push_back({k, d});
    endtask

    task automatic observe(input string name, input logic [3:0] k, input logic [63:0] d);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got unexpected event %h, expected none", name, {k, d});
        end else begin
            check(name, {k, d}, exp_q.pop_front());
        end
    endtask

    // {wr, rd, csreg, cmd_len, data_len, cmd} as seen on the controller side.
    function automatic logic [63:0] start_ev(input logic wr, input logic rd, input logic [3:0] csreg,
                                             input logic [5:0] cl, input logic [15:0] dl,
                                             input logic [31:0] cmd);
        return {4'b0, wr, rd, csreg, cl, dl, cmd};
    endfunction

    task automatic set_desc(input int r, input logic [1:0] cs, input logic wr, input logic [31:0] cmd,
                            input logic [5:0] cl, input logic [15:0] dl);
        req_cs_i[2*r +: 2]         = cs;
        req_wr_i[r]                = wr;
        req_cmd_i[32*r +: 32]      = cmd;
        req_cmd_len_i[6*r +: 6]    = cl;
        req_data_len_i[16*r +: 16] = dl;
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Monitor: one scoreboard pop per DUT-presented event.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (req_ready_o != '0) observe("ready", KReady, 64'(req_ready_o));
            if (spi_rd || spi_wr)
                observe("start", KStart,
                        {4'b0, spi_wr, spi_rd, spi_csreg, spi_cmd_len, spi_data_len, spi_cmd});
            if (spi_ctrl_data_tx_valid && spi_ctrl_data_tx_ready)
                observe("tx", KTx, 64'({req_tx_ready_o, spi_ctrl_data_tx}));
            if ((req_rx_valid_o & req_rx_ready_i) != '0)
                observe("rx", KRx, 64'({req_rx_valid_o, req_rx_data_o}));
            if (req_done_o != '0) observe("done", KDone, 64'(req_done_o));
            if (spi_swrst || req_err_o != '0) observe("err", KErr, 64'({spi_swrst, req_err_o}));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        int   idx;
        int   n;
        logic rx0_seen;
        logic swr;

        req_valid_i = '0; req_cs_i = '0; req_wr_i = '0; req_cmd_i = '0;
        req_cmd_len_i = '0; req_data_len_i = '0; req_tx_data_i = '0; req_tx_valid_i = '0;
        req_rx_ready_i = '0; spi_ctrl_data_tx_ready = 1'b0; spi_ctrl_data_rx = '0;
        spi_ctrl_data_rx_valid = 1'b0; eot = 1'b0;

        // Reset state
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_ready", req_ready_o, 0);
        check("rst_rdwr", {spi_wr, spi_rd}, 0);
        check("rst_csreg", spi_csreg, 0);
        check("rst_cmd", {spi_cmd, spi_cmd_len, spi_data_len}, 0);
        check("rst_stream", {spi_ctrl_data_tx_valid, spi_ctrl_data_rx_ready, req_tx_ready_o,
                             req_rx_valid_o}, 0);
        check("rst_done_err", {req_done_o, req_err_o, spi_swrst}, 0);
        HRESETn = 1'b1;
        step();

        // T1: req0 write, cs=1, two TX words
        set_desc(0, 2'd1, 1'b1, 32'h9F, 6'd8, 16'd64);
        req_valid_i = 2'b01;
        expect_ev(KReady, 64'h1);
        expect_ev(KStart, start_ev(1'b1, 1'b0, 4'b0010, 6'd8, 16'd64, 32'h9F));
        expect_ev(KTx, 64'({2'b01, 32'hA5A5_0000}));
        expect_ev(KTx, 64'({2'b01, 32'hA5A5_0001}));
        expect_ev(KDone, 64'h1);
        step();                                   // ISSUE
        req_valid_i = '0;
        req_tx_data_i[31:0] = 32'hA5A5_0000;
        req_tx_valid_i[0] = 1'b1;
        spi_ctrl_data_tx_ready = 1'b1;
        step();                                   // BUSY, word 0
        step();                                   // BUSY, word 1
        req_tx_data_i[31:0] = 32'hA5A5_0001;
        step();
        req_tx_valid_i[0] = 1'b0;
        eot = 1'b1;
        step();                                   // DONE
        eot = 1'b0;
        check("t1_done_timing", req_done_o, 2'b01);
        step();

        // T3: req1 read, 3 RX words, 5-cycle rx_ready stall
        set_desc(1, 2'd0, 1'b0, 32'h03, 6'd8, 16'd96);
        req_valid_i = 2'b10;
        req_rx_ready_i = 2'b01;
        expect_ev(KReady, 64'h2);
        expect_ev(KStart, start_ev(1'b0, 1'b1, 4'b0001, 6'd8, 16'd96, 32'h03));
        for (int i = 0; i < 3; i++) expect_ev(KRx, 64'({2'b10, rxw[i]}));
        expect_ev(KDone, 64'h2);
        step();                                   // ISSUE
        req_valid_i = '0;
        step();                                   // BUSY
        idx = 0;
        rx0_seen = 1'b0;
        for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
            spi_ctrl_data_rx = rxw[idx];
            spi_ctrl_data_rx_valid = 1'b1;
            req_rx_ready_i[1] = (cyc >= 5);
            @(negedge HCLK);
            if (req_rx_valid_o[0]) rx0_seen = 1'b1;
            if (spi_ctrl_data_rx_ready) idx++;
            step();
        end
        check("t3_rx_words", idx, 3);
        check("t3_rx0_quiet", rx0_seen, 0);
        spi_ctrl_data_rx_valid = 1'b0;
        req_rx_ready_i = '0;
        eot = 1'b1;
        step();
        eot = 1'b0;
        check("t3_done_timing", req_done_o, 2'b10);
        step();

        // T2: both requesters valid, eot held high -> grants 0,1,0,1
        set_desc(0, 2'd2, 1'b1, 32'hA0, 6'd8, 16'd0);
        set_desc(1, 2'd3, 1'b0, 32'hB1, 6'd8, 16'd0);
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) begin
                expect_ev(KReady, 64'h1);
                expect_ev(KStart, start_ev(1'b1, 1'b0, 4'b0100, 6'd8, 16'd0, 32'hA0));
                expect_ev(KDone, 64'h1);
            end else begin
                expect_ev(KReady, 64'h2);
                expect_ev(KStart, start_ev(1'b0, 1'b1, 4'b1000, 6'd8, 16'd0, 32'hB1));
                expect_ev(KDone, 64'h2);
            end
        end
        req_valid_i = 2'b11;
        eot = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 13) req_valid_i = '0;
        end
        eot = 1'b0;

        // T4: descriptor changed after acceptance must not leak through
        set_desc(0, 2'd2, 1'b1, 32'h1234_5678, 6'd16, 16'd0);
        req_valid_i = 2'b01;
        expect_ev(KReady, 64'h1);
        expect_ev(KStart, start_ev(1'b1, 1'b0, 4'b0100, 6'd16, 16'd0, 32'h1234_5678));
        expect_ev(KDone, 64'h1);
        step();                                   // ISSUE
        req_valid_i = '0;
        set_desc(0, 2'd0, 1'b0, 32'hDEAD_BEEF, 6'd31, 16'd7);
        step();                                   // BUSY
        check("t4_cmd_busy", spi_cmd, 32'h1234_5678);
        step();
        check("t4_cs_busy", {spi_csreg, spi_cmd_len}, {4'b0100, 6'd16});
        eot = 1'b1;
        step();                                   // DONE
        eot = 1'b0;
        check("t4_cmd_done", spi_cmd, 32'h1234_5678);
        step();

        // T5: reset mid-BUSY with a TX word pending
        set_desc(1, 2'd3, 1'b1, 32'h55, 6'd8, 16'd32);
        req_valid_i = 2'b10;
        req_tx_data_i[63:32] = 32'hCAFE_0001;
        req_tx_valid_i[1] = 1'b1;
        spi_ctrl_data_tx_ready = 1'b0;
        expect_ev(KReady, 64'h2);
        expect_ev(KStart, start_ev(1'b1, 1'b0, 4'b1000, 6'd8, 16'd32, 32'h55));
        step();
        req_valid_i = '0;
        step();                                   // BUSY
        check("t5_tx_pending", {spi_ctrl_data_tx_valid, spi_ctrl_data_tx}, {1'b1, 32'hCAFE_0001});
        #2;
        HRESETn = 1'b0;
        #1;
        check("t5_rst_rdwr_valid", {spi_wr, spi_rd, spi_ctrl_data_tx_valid, spi_ctrl_data_rx_ready}, 0);
        check("t5_rst_cmd", {spi_cmd, spi_csreg, spi_cmd_len, spi_data_len}, 0);
        check("t5_rst_req", {req_ready_o, req_tx_ready_o, req_done_o, req_err_o}, 0);
        step();
        step();
        HRESETn = 1'b1;
        req_tx_valid_i = '0;
        step();
        set_desc(0, 2'd2, 1'b1, 32'hA0, 6'd8, 16'd0);
        set_desc(1, 2'd3, 1'b0, 32'hB1, 6'd8, 16'd0);
        req_valid_i = 2'b11;
        expect_ev(KReady, 64'h1);
        expect_ev(KStart, start_ev(1'b1, 1'b0, 4'b0100, 6'd8, 16'd0, 32'hA0));
        expect_ev(KDone, 64'h1);
        step();
        req_valid_i = '0;
        step();
        eot = 1'b1;
        step();
        eot = 1'b0;
        step();

        // T6: no eot -> watchdog (when enabled) or indefinite BUSY
        set_desc(1, 2'd1, 1'b0, 32'h0B, 6'd8, 16'd32);
        req_valid_i = 2'b10;
        expect_ev(KReady, 64'h2);
        expect_ev(KStart, start_ev(1'b0, 1'b1, 4'b0010, 6'd8, 16'd32, 32'h0B));
`ifdef SPI_ARB_TIMEOUT_EN
        expect_ev(KErr, 64'b110);
`else
        expect_ev(KDone, 64'h2);
`endif
        step();
        req_valid_i = '0;
        step();                                   // first BUSY cycle
        n = 0;
        swr = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge HCLK);
            if (spi_swrst) begin
                swr = 1'b1;
                break;
            end
            n++;
            step();
        end
`ifdef SPI_ARB_TIMEOUT_EN
        check("t6_tmo_cycle", n, 20);
        step();
        check("t6_idle_after", {spi_cmd, spi_csreg}, 0);
`else
        check("t6_no_swrst", swr, 0);
        check("t6_still_busy", {spi_csreg, spi_cmd}, {4'b0010, 32'h0B});
        eot = 1'b1;
        step();
        eot = 1'b0;
        check("t6_done_timing", req_done_o, 2'b10);
`endif
        step();
        step();

        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
